dot_product_accumulator: RTL and testbench
==========================================

DOT_PRODUCT_ACCUMULATOR -- requirements
Module: dot_product_accumulator

Interface
REQ-001 The block SHALL have parameter IN_SIZE, default 24, width of the carry-save sum/carry pair from the upstream 12:2 compressor.
REQ-002 The block SHALL have parameter ACC_SIZE, default 32, width of the accumulator and result; legal range ACC_SIZE >= IN_SIZE.
REQ-003 The block SHALL have parameter CNT_SIZE, default 16, width of the beat counter.
REQ-004 The block SHALL have the following ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous flush of the in-progress dot product and the held result.
- sum_i  in  IN_SIZE  upstream sum vector.
- carry_i  in  IN_SIZE  upstream carry vector, already shifted.
- in_valid_i  in  1  sum_i/carry_i/in_last_i valid.
- in_last_i  in  1  beat is the final partial of the current dot product.
- in_ready_o  out  1  block accepts a beat this cycle.
- out_data_o  out  ACC_SIZE  signed dot-product result.
- out_cnt_o  out  CNT_SIZE  number of beats in out_data_o.
- out_ovf_o  out  1  overflow occurred in this result.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.

Function
REQ-005 A beat SHALL be accepted exactly when in_valid_i && in_ready_o && !clear_i.
REQ-006 Partial SHALL be (sum_i + carry_i) mod 2^IN_SIZE, read as two's complement and sign-extended to ACC_SIZE.
REQ-007 The sum SHALL be computed as acc + partial at ACC_SIZE+1 bits; overflow means the result lies outside the signed ACC_SIZE range.
REQ-008 The FSM SHALL have two states: ACCUM (out_valid_o=0) and HOLD (out_valid_o=1).
REQ-009 In ACCUM, in_ready_o SHALL be 1.
REQ-010 In HOLD, in_ready_o SHALL equal out_ready_i, so a drain and an accept can occur in the same cycle.
REQ-011 On an accepted non-last beat, the block SHALL update acc <= acc+partial, increment cnt (saturating at 2^CNT_SIZE-1), and set ovf sticky on overflow.
REQ-012 On an accepted last beat, the block SHALL load out_data_o, out_cnt_o and out_ovf_o from the updated values, zero acc, cnt and ovf, and enter or remain in HOLD.
REQ-013 Latency SHALL be one cycle: the result appears the cycle after the last beat is accepted.
REQ-014 In HOLD, out_ready_i=1 with no last beat accepted SHALL return the FSM to ACCUM.
REQ-015 In HOLD, out_ready_i=0 SHALL keep out_data_o, out_cnt_o and out_ovf_o stable and stall input.
REQ-016 clear_i SHALL take priority over a simultaneous beat: it zeros acc, cnt, ovf and the outputs and enters ACCUM.
REQ-017 A single-beat dot product (first beat has in_last_i=1) SHALL produce out_data_o=partial and out_cnt_o=1.
REQ-018 out_data_o, out_cnt_o and out_ovf_o SHALL be zero whenever out_valid_o=0.

Reset
REQ-019 While rst_ni=0, the block SHALL asynchronously force FSM=ACCUM and acc, cnt, ovf and all outputs to 0, including in_ready_o.
REQ-020 After reset deasserts, in_ready_o SHALL assert on the first clock edge.
REQ-021 A reset mid-dot-product SHALL discard all partial state; the next beat starts a new dot product.

Configuration
REQ-022 With macro DOT_PRODUCT_ACCUMULATOR_SAT_EN defined, an overflowing update SHALL clamp acc to +2^(ACC_SIZE-1)-1 or -2^(ACC_SIZE-1), according to the sign of the true sum.
REQ-023 With DOT_PRODUCT_ACCUMULATOR_SAT_EN undefined, acc SHALL wrap modulo 2^ACC_SIZE.
REQ-024 Overflow SHALL set ovf in both configurations.

Verification
REQ-025 Reset then 3 beats, sum/carry = (5,0),(0x000010,0x FFFFF8),(−3 as 24-bit, 0) with last on the third beat -> next cycle out_valid_o=1, out_data_o=10, out_cnt_o=3, out_ovf_o=0.
REQ-026 Result held with out_ready_i=0 for 4 cycles while in_valid_i=1 -> in_ready_o=0 and outputs stable; out_ready_i=1 together with a last beat (7,0) -> next cycle out_data_o=7, out_cnt_o=1.
REQ-027 ACC_SIZE=24, beats partial 0x7FFFFF then 1 (last) -> SAT_EN: out_data_o=0x7FFFFF, out_ovf_o=1; otherwise out_data_o=0x800000, out_ovf_o=1.
REQ-028 clear_i asserted together with a valid last beat after 2 accepted beats -> no result; out_valid_o=0; the next single last beat (9,0) gives out_data_o=9, out_cnt_o=1.
REQ-029 rst_ni pulsed low asynchronously between clock edges mid-accumulation -> outputs 0 immediately; a subsequent 1-beat dot product gives only that partial.

Source files
------------

// File: rtl/dot_product_accumulator.sv
// Accumulates carry-save partials from the upstream compressor into a signed dot product.
// Optional build macro DOT_PRODUCT_ACCUMULATOR_SAT_EN turns on accumulator saturation; the default wraps.
module dot_product_accumulator #(
    parameter int IN_SIZE  = 24,
    parameter int ACC_SIZE = 32,
    parameter int CNT_SIZE = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic [IN_SIZE-1:0]  sum_i,
    input  logic [IN_SIZE-1:0]  carry_i,
    input  logic                in_valid_i,
    input  logic                in_last_i,
    output logic                in_ready_o,
    output logic [ACC_SIZE-1:0] out_data_o,
    output logic [CNT_SIZE-1:0] out_cnt_o,
    output logic                out_ovf_o,
    output logic                out_valid_o,
    input  logic                out_ready_i
);

    typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t                      state_r;
    state_t                      state_next_s;
    logic                        started_r;
    logic signed [ACC_SIZE-1:0]  acc_r;
    logic [CNT_SIZE-1:0]         cnt_r;
    logic                        ovf_r;
    logic [ACC_SIZE-1:0]         out_data_r;
    logic [CNT_SIZE-1:0]         out_cnt_r;
    logic                        out_ovf_r;

    logic signed [IN_SIZE-1:0]   raw_s;
    logic signed [ACC_SIZE-1:0]  partial_s;
    logic signed [ACC_SIZE:0]    sum_wide_s;
    logic                        ovf_s;
    logic signed [ACC_SIZE-1:0]  acc_next_s;
    logic [CNT_SIZE-1:0]         cnt_next_s;
    logic                        ovf_next_s;
    logic                        ready_s;
    logic                        accept_s;
    logic                        drain_s;

    // Carry-save resolve, sign extension and one extra bit to expose overflow
    assign raw_s      = sum_i + carry_i;
    assign partial_s  = ACC_SIZE'(raw_s);
    assign sum_wide_s = (ACC_SIZE+1)'(acc_r) + (ACC_SIZE+1)'(partial_s);
    assign ovf_s      = sum_wide_s[ACC_SIZE] ^ sum_wide_s[ACC_SIZE-1];
    assign cnt_next_s = (cnt_r == {CNT_SIZE{1'b1}}) ? cnt_r : cnt_r + {{(CNT_SIZE-1){1'b0}}, 1'b1};
    assign ovf_next_s = ovf_r | ovf_s;

    assign accept_s   = in_valid_i & ready_s & ~clear_i;
    assign drain_s    = (state_r == HOLD) & out_ready_i;

    // Accumulator update: clamp on overflow when saturation is built in, otherwise wrap
    always_comb begin
        acc_next_s = sum_wide_s[ACC_SIZE-1:0];
`ifdef DOT_PRODUCT_ACCUMULATOR_SAT_EN
        if (ovf_s) begin
            if (sum_wide_s[ACC_SIZE]) begin
                acc_next_s = {1'b1, {(ACC_SIZE-1){1'b0}}};
            end else begin
                acc_next_s = {1'b0, {(ACC_SIZE-1){1'b1}}};
            end
        end else begin
            acc_next_s = sum_wide_s[ACC_SIZE-1:0];
        end
`endif
    end

    // Input handshake: held low until the first edge after reset; in HOLD it follows the consumer
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ACCUM:   ready_s = started_r;
            HOLD:    ready_s = started_r & out_ready_i;
            default: ready_s = 1'b0;
        endcase
    end

    // Next-state logic; clear wins over everything else
    always_comb begin
        state_next_s = state_r;
        if (clear_i) begin
            state_next_s = ACCUM;
        end else if (accept_s && in_last_i) begin
            state_next_s = HOLD;
        end else if (drain_s) begin
            state_next_s = ACCUM;
        end else begin
            state_next_s = state_r;
        end
    end

    // State register and post-reset ready enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ACCUM;
            started_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            started_r <= 1'b1;
        end
    end

    // Running accumulation and the held result; outputs are kept at zero outside HOLD
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_r      <= '0;
            cnt_r      <= '0;
            ovf_r      <= 1'b0;
            out_data_r <= '0;
            out_cnt_r  <= '0;
            out_ovf_r  <= 1'b0;
        end else if (clear_i) begin
            acc_r      <= '0;
            cnt_r      <= '0;
            ovf_r      <= 1'b0;
            out_data_r <= '0;
            out_cnt_r  <= '0;
            out_ovf_r  <= 1'b0;
        end else if (accept_s && in_last_i) begin
            out_data_r <= acc_next_s;
            out_cnt_r  <= cnt_next_s;
            out_ovf_r  <= ovf_next_s;
            acc_r      <= '0;
            cnt_r      <= '0;
            ovf_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                acc_r <= acc_next_s;
                cnt_r <= cnt_next_s;
                ovf_r <= ovf_next_s;
            end
            if (drain_s) begin
                out_data_r <= '0;
                out_cnt_r  <= '0;
                out_ovf_r  <= 1'b0;
            end
        end
    end

    assign in_ready_o  = ready_s;
    assign out_valid_o = (state_r == HOLD);
    assign out_data_o  = out_data_r;
    assign out_cnt_o   = out_cnt_r;
    assign out_ovf_o   = out_ovf_r;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator: a default instance plus a 24-bit accumulator instance.
module tb_dot_product_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [23:0] sum;
    logic [23:0] carry;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic [31:0] out_data;
    logic [15:0] out_cnt;
    logic        out_ovf;
    logic        out_valid;

    logic        in_ready24;
    logic [23:0] out_data24;
    logic [15:0] out_cnt24;
    logic        out_ovf24;
    logic        out_valid24;

    int n_checks = 0;
    int n_errors = 0;

    dot_product_accumulator dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .sum_i(sum), .carry_i(carry), .in_valid_i(in_valid), .in_last_i(in_last),
        .in_ready_o(in_ready), .out_data_o(out_data), .out_cnt_o(out_cnt),
        .out_ovf_o(out_ovf), .out_valid_o(out_valid), .out_ready_i(out_ready)
    );

    dot_product_accumulator #(.ACC_SIZE(24)) dut24 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .sum_i(sum), .carry_i(carry), .in_valid_i(in_valid), .in_last_i(in_last),
        .in_ready_o(in_ready24), .out_data_o(out_data24), .out_cnt_o(out_cnt24),
        .out_ovf_o(out_ovf24), .out_valid_o(out_valid24), .out_ready_i(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [23:0] s, input logic [23:0] c, input logic last);
        sum      = s;
        carry    = c;
        in_last  = last;
        in_valid = 1'b1;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        sum      = 24'd0;
        carry    = 24'd0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0;
        idle();
        #1;
        check_value("rst_ready",  64'(in_ready),  64'd0);
        check_value("rst_valid",  64'(out_valid), 64'd0);
        check_value("rst_data",   64'(out_data),  64'd0);
        check_value("rst_cnt",    64'(out_cnt),   64'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check_value("ready_before_edge", 64'(in_ready), 64'd0);
        step();
        check_value("ready_first_edge",  64'(in_ready), 64'd1);

        // Three-beat dot product: 5 + 8 + (-3)
        beat(24'd5,        24'd0,        1'b0);
        check_value("mid_valid", 64'(out_valid), 64'd0);
        beat(24'h000010,   24'hFFFFF8,   1'b0);
        beat(24'hFFFFFD,   24'd0,        1'b1);
        check_value("dp3_valid", 64'(out_valid), 64'd1);
        check_value("dp3_data",  64'(out_data),  64'd10);
        check_value("dp3_cnt",   64'(out_cnt),   64'd3);
        check_value("dp3_ovf",   64'(out_ovf),   64'd0);

        // Back-pressure: result held, input stalled
        sum = 24'd7; carry = 24'd0; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_value("stall_ready", 64'(in_ready),  64'd0);
            check_value("stall_data",  64'(out_data),  64'd10);
            check_value("stall_cnt",   64'(out_cnt),   64'd3);
            check_value("stall_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check_value("drain_ready", 64'(in_ready), 64'd1);
        step();
        check_value("chain_valid", 64'(out_valid), 64'd1);
        check_value("chain_data",  64'(out_data),  64'd7);
        check_value("chain_cnt",   64'(out_cnt),   64'd1);
        idle();
        step();
        check_value("drained_valid", 64'(out_valid), 64'd0);
        check_value("drained_data",  64'(out_data),  64'd0);
        check_value("drained_cnt",   64'(out_cnt),   64'd0);

        // Overflow in the 24-bit accumulator; the 32-bit one just sees a positive sum
        beat(24'h7FFFFF, 24'd0, 1'b0);
        beat(24'h000001, 24'd0, 1'b1);
`ifdef DOT_PRODUCT_ACCUMULATOR_SAT_EN
        check_value("ovf24_data", 64'(out_data24), 64'h7FFFFF);
`else
        check_value("ovf24_data", 64'(out_data24), 64'h800000);
`endif
        check_value("ovf24_flag", 64'(out_ovf24),  64'd1);
        check_value("ovf24_cnt",  64'(out_cnt24),  64'd2);
        check_value("ovf32_data", 64'(out_data),   64'h800000);
        check_value("ovf32_flag", 64'(out_ovf),    64'd0);
        idle();
        step();
        check_value("ovf_drained", 64'(out_ovf24), 64'd0);

        // Clear beats a simultaneous last beat
        beat(24'd1, 24'd0, 1'b0);
        beat(24'd2, 24'd0, 1'b0);
        clear = 1'b1;
        beat(24'd4, 24'd0, 1'b1);
        check_value("clear_valid", 64'(out_valid), 64'd0);
        check_value("clear_data",  64'(out_data),  64'd0);
        clear = 1'b0;
        beat(24'd9, 24'd0, 1'b1);
        check_value("post_clear_data", 64'(out_data), 64'd9);
        check_value("post_clear_cnt",  64'(out_cnt),  64'd1);
        idle();
        step();

        // Async reset mid-accumulation after a drain-and-accept cycle
        beat(24'd100, 24'd0, 1'b0);
        beat(24'd3,   24'd0, 1'b1);
        check_value("pre_rst_data", 64'(out_data), 64'd103);
        beat(24'd50,  24'd0, 1'b0);
        check_value("drain_accept_valid", 64'(out_valid), 64'd0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_value("async_rst_ready", 64'(in_ready),  64'd0);
        check_value("async_rst_valid", 64'(out_valid), 64'd0);
        check_value("async_rst_data",  64'(out_data),  64'd0);
        step();
        rst_n = 1'b1;
        step();
        beat(24'd6, 24'd0, 1'b1);
        check_value("post_rst_data", 64'(out_data), 64'd6);
        check_value("post_rst_cnt",  64'(out_cnt),  64'd1);
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
